// File: rtl/inst_fetch_queue.sv
// Circular instruction fetch queue between the PC/fetch stage and decode.
// Flushes empty the queue in one edge; storage itself is never reset.
module inst_fetch_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ECODE_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid_i,
  input  logic [31:0]          fetch_pc_i,
  input  logic [31:0]          fetch_inst_i,
  input  logic [5:0]           fetch_is_exception_i,
  input  logic [6*ECODE_W-1:0] fetch_exception_cause_i,
  output logic                 fetch_ready_o,
  input  logic                 branch_flush,
  input  logic                 exception_flush,
  input  logic                 dec_ready_i,
  output logic                 dec_valid_o,
  output logic [31:0]          dec_pc_o,
  output logic [31:0]          dec_inst_o,
  output logic [5:0]           dec_is_exception_o,
  output logic [6*ECODE_W-1:0] dec_exception_cause_o,
  output logic                 stall_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
  localparam logic [CW-1:0] StallCount = CW'(DEPTH - 2);
  localparam logic [31:0]   NopInst    = 32'h0340_0000;

  logic [31:0]          pc_mem    [DEPTH];
  logic [31:0]          inst_mem  [DEPTH];
  logic [5:0]           exc_mem   [DEPTH];
  logic [6*ECODE_W-1:0] cause_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic flush;
  logic wr_en;
  logic rd_en;
  logic [31:0] inst_in;

  assign flush         = branch_flush | exception_flush;
  assign fetch_ready_o = (count_q != FullCount);
  assign dec_valid_o   = (count_q != '0) & ~flush;
  assign stall_o       = (count_q >= StallCount);
  assign count_o       = count_q;

  // Full refuses a write even when decode drains in the same cycle.
  assign wr_en = fetch_valid_i & fetch_ready_o & ~flush;
  assign rd_en = dec_valid_o & dec_ready_i;

  // Faulting fetches carry a nop so decode never acts on a bogus word.
  assign inst_in = (|fetch_is_exception_i) ? NopInst : fetch_inst_i;

  assign dec_pc_o              = pc_mem[rd_ptr_q];
  assign dec_inst_o            = inst_mem[rd_ptr_q];
  assign dec_is_exception_o    = exc_mem[rd_ptr_q];
  assign dec_exception_cause_o = cause_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_i;
      inst_mem[wr_ptr_q]  <= inst_in;
      exc_mem[wr_ptr_q]   <= fetch_is_exception_i;
      cause_mem[wr_ptr_q] <= fetch_exception_cause_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a vector table for the main scenarios
// plus hand-written sequences for pointer wrap and asynchronous reset.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ECODE_W = 7;
  localparam int unsigned CAW     = 6 * ECODE_W;
  localparam logic [CAW-1:0] AdefCause = 42'h8 << 28;

  logic            clk;
  logic            rst;
  logic            fetch_valid_i;
  logic [31:0]     fetch_pc_i;
  logic [31:0]     fetch_inst_i;
  logic [5:0]      fetch_is_exception_i;
  logic [CAW-1:0]  fetch_exception_cause_i;
  logic            fetch_ready_o;
  logic            branch_flush;
  logic            exception_flush;
  logic            dec_ready_i;
  logic            dec_valid_o;
  logic [31:0]     dec_pc_o;
  logic [31:0]     dec_inst_o;
  logic [5:0]      dec_is_exception_o;
  logic [CAW-1:0]  dec_exception_cause_o;
  logic            stall_o;
  logic [3:0]      count_o;

  inst_fetch_queue #(
    .DEPTH  (DEPTH),
    .ECODE_W(ECODE_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fetch_valid_i          (fetch_valid_i),
    .fetch_pc_i             (fetch_pc_i),
    .fetch_inst_i           (fetch_inst_i),
    .fetch_is_exception_i   (fetch_is_exception_i),
    .fetch_exception_cause_i(fetch_exception_cause_i),
    .fetch_ready_o          (fetch_ready_o),
    .branch_flush           (branch_flush),
    .exception_flush        (exception_flush),
    .dec_ready_i            (dec_ready_i),
    .dec_valid_o            (dec_valid_o),
    .dec_pc_o               (dec_pc_o),
    .dec_inst_o             (dec_inst_o),
    .dec_is_exception_o     (dec_is_exception_o),
    .dec_exception_cause_o  (dec_exception_cause_o),
    .stall_o                (stall_o),
    .count_o                (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             fv;
    logic [31:0]    pc;
    logic [31:0]    inst;
    logic [5:0]     exc;
    logic [CAW-1:0] cause;
    bit             bf;
    bit             ef;
    bit             rdy;
    bit             e_valid;
    bit             e_ready;
    bit             e_stall;
    logic [3:0]     e_count;
    bit             chk;
    logic [31:0]    e_pc;
    logic [31:0]    e_inst;
    logic [5:0]     e_exc;
    logic [CAW-1:0] e_cause;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected flags follow from the occupancy the vector expects at cycle start.
  task automatic addv(input bit fv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [5:0] exc, input logic [CAW-1:0] cause,
                      input bit bf, input bit ef, input bit rdy, input int ec,
                      input bit chk, input logic [31:0] epc, input logic [31:0] einst,
                      input logic [5:0] eexc, input logic [CAW-1:0] ecause);
    vec_t v;
    v.fv = fv; v.pc = pc; v.inst = inst; v.exc = exc; v.cause = cause;
    v.bf = bf; v.ef = ef; v.rdy = rdy;
    v.e_count = 4'(ec);
    v.e_valid = (ec != 0) && !bf && !ef;
    v.e_ready = (ec != 8);
    v.e_stall = (ec >= 6);
    v.chk = chk; v.e_pc = epc; v.e_inst = einst; v.e_exc = eexc; v.e_cause = ecause;
    vecs.push_back(v);
  endtask

  task automatic vw(input logic [31:0] pc, input logic [31:0] inst, input bit rdy,
                    input int ec, input bit chk, input logic [31:0] epc,
                    input logic [31:0] einst);
    addv(1, pc, inst, '0, '0, 0, 0, rdy, ec, chk, epc, einst, '0, '0);
  endtask

  task automatic vi(input bit rdy, input int ec, input bit chk, input logic [31:0] epc,
                    input logic [31:0] einst);
    addv(0, '0, '0, '0, '0, 0, 0, rdy, ec, chk, epc, einst, '0, '0);
  endtask

  task automatic drive(input bit fv, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy);
    fetch_valid_i           = fv;
    fetch_pc_i              = pc;
    fetch_inst_i            = inst;
    fetch_is_exception_i    = '0;
    fetch_exception_cause_i = '0;
    branch_flush            = 1'b0;
    exception_flush         = 1'b0;
    dec_ready_i             = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input bit v, input bit r, input bit s,
                             input int c);
    check({tag, ".valid"}, 64'(dec_valid_o), 64'(v));
    check({tag, ".ready"}, 64'(fetch_ready_o), 64'(r));
    check({tag, ".stall"}, 64'(stall_o), 64'(s));
    check({tag, ".count"}, 64'(count_o), 64'(c));
  endtask

  initial begin
    // Basic write then read
    vw(32'h1c00_0000, 32'h0280_0421, 0, 0, 0, '0, '0);
    vi(0, 1, 1, 32'h1c00_0000, 32'h0280_0421);
    vi(1, 1, 1, 32'h1c00_0000, 32'h0280_0421);
    // Fill to full, stall at 6, refused 9th write
    for (int k = 0; k < 8; k++)
      vw(32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), 0, k, k > 0, 32'h1000, 32'hA0);
    vw(32'h2000, 32'hBB, 0, 8, 1, 32'h1000, 32'hA0);
    vi(0, 8, 1, 32'h1000, 32'hA0);
    // Full with simultaneous read: write refused, then retried
    vw(32'h3000, 32'h33, 1, 8, 1, 32'h1000, 32'hA0);
    vw(32'h3000, 32'h33, 0, 7, 1, 32'h1004, 32'hA1);
    for (int k = 1; k < 8; k++)
      vi(1, 9 - k, 1, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k));
    vi(1, 1, 1, 32'h3000, 32'h33);
    vi(0, 0, 0, '0, '0);
    // Branch flush with concurrent write, then exception flush
    for (int k = 0; k < 5; k++)
      vw(32'h4000 + 32'(4 * k), 32'hC0 + 32'(k), 0, k, k > 0, 32'h4000, 32'hC0);
    addv(1, 32'h5000, 32'h55, '0, '0, 1, 0, 1, 5, 0, '0, '0, '0, '0);
    vi(1, 0, 0, '0, '0);
    vw(32'h6000, 32'h66, 0, 0, 0, '0, '0);
    addv(1, 32'h5004, 32'h56, '0, '0, 0, 1, 1, 1, 0, '0, '0, '0, '0);
    vi(1, 0, 0, '0, '0);
    vw(32'h6004, 32'h67, 0, 0, 0, '0, '0);
    vi(1, 1, 1, 32'h6004, 32'h67);
    // Fetch exception: nop substituted, flags and cause kept
    addv(1, 32'h1c00_0002, 32'h1234_5678, 6'b010000, AdefCause, 0, 0, 0, 0,
         0, '0, '0, '0, '0);
    addv(0, '0, '0, '0, '0, 0, 0, 1, 1, 1, 32'h1c00_0002, 32'h0340_0000, 6'b010000,
         AdefCause);
    vi(0, 0, 0, '0, '0);

    drive(0, '0, '0, 0);
    rst = 1'b0;
    #1;
    check_flags("reset", 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      vec_t v;
      string tag;
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      drive(v.fv, v.pc, v.inst, v.rdy);
      fetch_is_exception_i    = v.exc;
      fetch_exception_cause_i = v.cause;
      branch_flush            = v.bf;
      exception_flush         = v.ef;
      #1;
      check_flags(tag, v.e_valid, v.e_ready, v.e_stall, int'(v.e_count));
      if (v.chk) begin
        check({tag, ".pc"}, 64'(dec_pc_o), 64'(v.e_pc));
        check({tag, ".inst"}, 64'(dec_inst_o), 64'(v.e_inst));
        check({tag, ".exc"}, 64'(dec_is_exception_o), 64'(v.e_exc));
        check({tag, ".cause"}, 64'(dec_exception_cause_o), 64'(v.e_cause));
      end
      step();
    end

    // Streaming through the wrap point: one in, one out each cycle
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h7000 + 32'(4 * i), 32'hE0 + 32'(i), 1);
      #1;
      if (i > 0) begin
        check($sformatf("wrap%0d.count", i), 64'(count_o), 64'd1);
        check($sformatf("wrap%0d.pc", i), 64'(dec_pc_o), 64'(32'h7000 + 32'(4 * (i - 1))));
        check($sformatf("wrap%0d.inst", i), 64'(dec_inst_o), 64'(32'hE0 + 32'(i - 1)));
      end
      step();
    end
    drive(0, '0, '0, 1);
    #1;
    check("wrap_last.pc", 64'(dec_pc_o), 64'(32'h7024));
    check("wrap_last.inst", 64'(dec_inst_o), 64'(32'hE9));
    step();
    drive(0, '0, '0, 0);
    #1;
    check_flags("wrap_end", 0, 1, 0, 0);

    // Asynchronous reset mid-stream, asserted between clock edges
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h8000 + 32'(4 * i), 32'hF0, 0);
      step();
    end
    drive(0, '0, '0, 0);
    #1;
    check_flags("prerst", 1, 1, 1, 7);
    #1;
    rst = 1'b0;
    #1;
    check_flags("async_rst", 0, 1, 0, 0);
    step();
    rst = 1'b1;
    step();
    check_flags("post_rst", 0, 1, 0, 0);
    step();
    check_flags("post_rst2", 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >= 4).
REQ-002 SHALL have parameter ECODE_W, default 7, width of one exception-cause code.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-low.
REQ-005 SHALL have port fetch_valid_i  in  1  a fetched instruction is presented.
REQ-006 SHALL have port fetch_pc_i  in  32  PC of the fetched instruction.
REQ-007 SHALL have port fetch_inst_i  in  32  instruction word.
REQ-008 SHALL have port fetch_is_exception_i  in  6  per-stage exception flags from fetch.
REQ-009 SHALL have port fetch_exception_cause_i  in  6*ECODE_W  per-stage cause codes.
REQ-010 SHALL have port fetch_ready_o  out  1  queue accepts a write this cycle.
REQ-011 SHALL have port branch_flush  in  1  branch mispredict flush.
REQ-012 SHALL have port exception_flush  in  1  exception/ertn flush.
REQ-013 SHALL have port dec_ready_i  in  1  decode consumes the head entry.
REQ-014 SHALL have port dec_valid_o  out  1  head entry is valid.
REQ-015 SHALL have ports dec_pc_o (32), dec_inst_o (32), dec_is_exception_o (6), dec_exception_cause_o (6*ECODE_W), all out, head-entry fields.
REQ-016 SHALL have port stall_o  out  1  almost-full back-pressure to the PC generator.
REQ-017 SHALL have port count_o  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-018 SHALL be a circular FIFO: write pointer, read pointer (clog2(DEPTH) bits, wrap modulo DEPTH), and occupancy count.
REQ-019 SHALL drive fetch_ready_o = (count != DEPTH), combinationally; a write occurs when fetch_valid_i && fetch_ready_o && no flush.
REQ-020 SHALL drive dec_valid_o = (count != 0) && !branch_flush && !exception_flush, combinationally; a read occurs when dec_valid_o && dec_ready_i.
REQ-021 SHALL present the head entry on the dec_* outputs directly from storage; with dec_valid_o low the dec_* data is don't-care.
REQ-022 SHALL have 1-cycle write-to-output latency; no bypass: a write into an empty queue raises dec_valid_o the next cycle.
REQ-023 SHALL update count +1 on write only, -1 on read only, unchanged on simultaneous read and write.
REQ-024 SHALL refuse writes when full, even if a read occurs in the same cycle; the producer retries.
REQ-025 SHALL store dec_inst = 32'h03400000 (nop) instead of fetch_inst_i when any fetch_is_exception_i bit is set; PC, flags and causes are stored unchanged.
REQ-026 SHALL drive stall_o = (count >= DEPTH-2), combinationally, to cover two fetches in flight.
REQ-027 SHALL on branch_flush or exception_flush (either or both) clear both pointers and count at the next edge, drop any same-cycle write and perform no read.
REQ-028 SHALL give flush priority over every other event; the cycle after a flush, the queue is empty and accepts writes.

Reset
REQ-029 SHALL on rst low, asynchronously, clear both pointers and count, giving dec_valid_o=0, fetch_ready_o=1, stall_o=0, count_o=0.
REQ-030 SHALL not require storage contents to be reset.
REQ-031 SHALL treat reset asserted mid-operation as empty: all queued entries are discarded and no output pulse appears on release.

Verification
REQ-032 SHALL cover: reset, then write pc=0x1c000000 inst=0x02800421 -> dec_valid_o=1 next cycle with the same pc/inst, count_o=1.
REQ-033 SHALL cover: 8 writes with dec_ready_i=0 -> stall_o=1 at count 6, fetch_ready_o=0 at count 8; a 9th write is not accepted; drained order matches write order.
REQ-034 SHALL cover: full queue, simultaneous valid write and read -> count drops to 7, write refused; the next write then succeeds.
REQ-035 SHALL cover: 5 entries queued, branch_flush pulse with a concurrent write -> dec_valid_o=0 that cycle, count_o=0 next cycle, flushed write absent.
REQ-036 SHALL cover: write pc=0x1c000002 with is_exception=6'b010000, cause slot4=ADEF -> dec_inst_o=0x03400000, flags/cause preserved.
REQ-037 SHALL cover: 10 writes and reads across the wrap point -> pointers wrap and data stays correct in order; rst low mid-stream -> outputs cleared immediately, independent of clk.
